muldiv_unit: RTL

Iterative RV32M multiply/divide execute unit, directly downstream of the register file. It takes the two register read values plus funct3 and the destination register, and computes over multiple cycles. It then returns a 32-bit result with a one-cycle done pulse to the writeback path. The shift-add / restoring-divide datapath trades latency for area.

---
 rtl/muldiv_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
//==============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide execute unit. A shift-add
//               multiplier and a restoring divider share one operand register
//               pair and one step counter. Operations take 34 cycles from
//               accept to writeback. Divide-by-zero and signed overflow take a
//               one-cycle fast path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clock     in   system clock, rising-edge
//   reset     in   asynchronous active-high reset
//   start     in   request, accepted only while busy is low
//   funct3    in   [2:0] RV32M operation select
//   operandA  in   [XLEN-1:0] rs1 value
//   operandB  in   [XLEN-1:0] rs2 value
//   rdIn      in   [4:0] destination register index
//   busy      out  high from the accept edge until done drops
//   done      out  one-cycle result-valid pulse
//   result    out  [XLEN-1:0] computed value, held until next done
//   rdOut     out  [4:0] destination index latched at accept
//   rWrite    out  register-file write strobe (same as done)
//==============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operandA,
   input  logic [XLEN-1:0] operandB,
   input  logic [4:0]      rdIn,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rdOut,
   output logic            rWrite
);

   localparam int            CW        = $clog2(ITER);
   localparam logic [CW-1:0] c_last    = CW'(ITER - 1);

   localparam logic [2:0]    S_IDLE    = 3'd0;
   localparam logic [2:0]    S_MUL     = 3'd1;
   localparam logic [2:0]    S_DIV     = 3'd2;
   localparam logic [2:0]    S_FIX     = 3'd3;
   localparam logic [2:0]    S_DONE    = 3'd4;

   localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]      r_state;
   logic [2:0]      w_next_state;
   logic [CW-1:0]   r_count;
   logic [2:0]      r_funct3;
   logic            r_neg;
   // r_hi/r_lo hold the 64-bit product for multiplies and the
   // remainder/quotient pair for divides; r_mcand is multiplicand or divisor.
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_mcand;

   //---------------------------------------------------------------------------
   // Accept-time operand decode
   //---------------------------------------------------------------------------
   logic            w_accept;
   logic            w_a_signed;
   logic            w_b_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_div_zero;
   logic            w_div_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_special_val;
   logic            w_neg_result;

   assign w_accept   = start && (r_state == S_IDLE);
   // MULH and DIV/REM treat both operands as signed; MULHSU only rs1.
   assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3[2] && !funct3[0]);
   assign w_b_signed = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
   assign w_a_neg    = w_a_signed && operandA[XLEN-1];
   assign w_b_neg    = w_b_signed && operandB[XLEN-1];
   assign w_a_mag    = w_a_neg ? (~operandA + 1'b1) : operandA;
   assign w_b_mag    = w_b_neg ? (~operandB + 1'b1) : operandB;

   assign w_div_zero = funct3[2] && (operandB == '0);
   assign w_div_ovf  = funct3[2] && !funct3[0] &&
                       (operandA == c_int_min) && (operandB == '1);
   assign w_special  = w_div_zero || w_div_ovf;
   // Overflow quotient is INT_MIN, which is operandA itself.
   assign w_special_val = w_div_zero ? (funct3[1] ? operandA : '1)
                                     : (funct3[1] ? '0 : operandA);
   // Remainder follows the dividend sign; all other results follow the
   // product of signs (unsigned operands never report negative).
   assign w_neg_result = (funct3[2] && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

   //---------------------------------------------------------------------------
   // Iteration datapath
   //---------------------------------------------------------------------------
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_div_shift;
   logic [XLEN:0]     w_div_diff;
   logic              w_div_ge;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_c;
   logic [XLEN-1:0]   w_div_sel;
   logic [XLEN-1:0]   w_div_c;
   logic [XLEN-1:0]   w_fix_val;

   assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
   assign w_div_shift = {r_hi, r_lo[XLEN-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});

   assign w_prod      = {r_hi, r_lo};
   assign w_prod_c    = r_neg ? (~w_prod + 1'b1) : w_prod;
   assign w_div_sel   = r_funct3[1] ? r_hi : r_lo;
   assign w_div_c     = r_neg ? (~w_div_sel + 1'b1) : w_div_sel;
   assign w_fix_val   = r_funct3[2]             ? w_div_c :
                        (r_funct3[1:0] == 2'b00) ? w_prod_c[XLEN-1:0]
                                                 : w_prod_c[2*XLEN-1:XLEN];

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_special)      w_next_state = S_DONE;
               else if (funct3[2]) w_next_state = S_DIV;
               else                w_next_state = S_MUL;
            end
         end
         S_MUL:   if (r_count == c_last) w_next_state = S_FIX;
         S_DIV:   if (r_count == c_last) w_next_state = S_FIX;
         S_FIX:   w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: outputs
   //---------------------------------------------------------------------------
   always_comb begin
      busy   = (r_state != S_IDLE);
      done   = (r_state == S_DONE);
      rWrite = (r_state == S_DONE);
   end

   //---------------------------------------------------------------------------
   // Datapath registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count  <= '0;
         r_funct3 <= '0;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_mcand  <= '0;
         result   <= '0;
         rdOut    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_count  <= '0;
                  r_funct3 <= funct3;
                  r_neg    <= w_neg_result;
                  r_hi     <= '0;
                  r_lo     <= w_a_mag;
                  r_mcand  <= w_b_mag;
                  rdOut    <= rdIn;
                  if (w_special) begin
                     result <= w_special_val;
                  end
               end
            end
            S_MUL: begin
               {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
               r_count      <= r_count + 1'b1;
            end
            S_DIV: begin
               r_hi    <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
               r_lo    <= {r_lo[XLEN-2:0], w_div_ge};
               r_count <= r_count + 1'b1;
            end
            S_FIX: begin
               result <= w_fix_val;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
